// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array drain path.
package systolic_pkg;

  localparam int unsigned D_W   = 8;
  localparam int unsigned N     = 3;
  localparam int unsigned RES_W = 2 * D_W;
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankReading
  } bank_state_e;

endpackage

// File: rtl/drain_bank.sv
// One N x N result bank: a write port per array row, a single random-access read port.
module drain_bank
  import systolic_pkg::*;
#(
  parameter int unsigned Width = RES_W,
  parameter int unsigned Dim   = N,
  parameter int unsigned IdxW  = IDX_W
) (
  input  logic                      clk_i,
  input  logic [Dim-1:0]            we_i,
  input  logic [Dim-1:0][IdxW-1:0]  wcol_i,
  input  logic [Dim-1:0][Width-1:0] wdata_i,
  input  logic [IdxW-1:0]           rrow_i,
  input  logic [IdxW-1:0]           rcol_i,
  output logic [Width-1:0]          rdata_o
);

  logic [Width-1:0] mem_q [Dim][Dim];

  // Data storage needs no reset; validity is tracked by the bank state in the collector.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < Dim; k++) begin
      if (we_i[k]) begin
        mem_q[k][wcol_i[k]] <= wdata_i[k];
      end
    end
  end

  assign rdata_o = mem_q[rrow_i][rcol_i];

endmodule

// File: rtl/systolic_drain_collector.sv
// Reassembles right-to-left row drain streams into double-buffered N x N tiles and
// streams completed tiles out in row-major order over a valid/ready handshake.
module systolic_drain_collector #(
  parameter int unsigned D_W = systolic_pkg::D_W,
  parameter int unsigned N   = systolic_pkg::N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0][2*D_W-1:0]   m2,
  input  logic [N-1:0]              valid_m2,
  output logic [2*D_W-1:0]          out_data,
  output logic [$clog2(N)-1:0]      out_row,
  output logic [$clog2(N)-1:0]      out_col,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      tile_done,
  output logic                      overflow,
  output logic                      proto_err
);
  import systolic_pkg::*;

  localparam int unsigned ResW = 2 * D_W;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(N + 1);

  bank_state_e             st_q [2];
  bank_state_e             st_d [2];
  logic                    fill_q, fill_d, rd_bank_q, rd_bank_d;
  logic [N-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]         rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic                    tile_done_q, ovf_q, ovf_d, perr_q, perr_d;
  logic [N-1:0]            beat_ok;
  logic [N-1:0][IdxW-1:0]  wcol;
  logic                    filling, complete, accept, at_last, last_acc;
  logic [ResW-1:0]         rdata [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]     <= BankFilling;
      st_q[1]     <= BankEmpty;
      fill_q      <= 1'b0;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      tile_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      fill_q      <= fill_d;
      rd_bank_q   <= rd_bank_d;
      cnt_q       <= cnt_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      tile_done_q <= complete;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  // Beat acceptance and per-row column counters for the fill bank.
  always_comb begin
    filling  = (st_q[fill_q] == BankFilling);
    cnt_d    = cnt_q;
    beat_ok  = '0;
    wcol     = '0;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    complete = filling;
    for (int k = 0; k < N; k++) begin
      wcol[k] = IdxW'(N - 1) - IdxW'(cnt_q[k]);
      if (valid_m2[k]) begin
        if (!filling) begin
          ovf_d = 1'b1;
        end else if (cnt_q[k] == CntW'(N)) begin
          perr_d = 1'b1;
        end else begin
          beat_ok[k] = 1'b1;
          cnt_d[k]   = cnt_q[k] + 1'b1;
        end
      end
      if (cnt_d[k] != CntW'(N)) complete = 1'b0;
    end
    if (complete) cnt_d = '0;
  end

  assign at_last  = (rd_row_q == IdxW'(N - 1)) && (rd_col_q == IdxW'(N - 1));
  assign accept   = out_valid && out_ready;
  assign last_acc = accept && at_last;

  // Bank state machines: fill and read pointers alternate strictly between the two banks.
  always_comb begin
    st_d      = st_q;
    fill_d    = fill_q;
    rd_bank_d = rd_bank_q;
    if (last_acc) begin
      st_d[rd_bank_q] = BankEmpty;
      rd_bank_d       = ~rd_bank_q;
      if (st_q[~rd_bank_q] == BankFull) st_d[~rd_bank_q] = BankReading;
    end
    if (complete) begin
      st_d[fill_q] = (st_q[~fill_q] == BankReading && !last_acc) ? BankFull : BankReading;
      if (st_q[~fill_q] == BankEmpty || last_acc) begin
        st_d[~fill_q] = BankFilling;
        fill_d        = ~fill_q;
      end
    end else if (!filling && last_acc) begin
      // Freed bank takes over filling; beats sampled on this edge were already dropped.
      st_d[rd_bank_q] = BankFilling;
      fill_d          = rd_bank_q;
    end
  end

  always_comb begin
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    if (accept) begin
      if (rd_col_q == IdxW'(N - 1)) begin
        rd_col_d = '0;
        rd_row_d = (rd_row_q == IdxW'(N - 1)) ? '0 : rd_row_q + 1'b1;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    drain_bank #(
      .Width (ResW),
      .Dim   (N),
      .IdxW  (IdxW)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (beat_ok & {N{fill_q == 1'(b)}}),
      .wcol_i  (wcol),
      .wdata_i (m2),
      .rrow_i  (rd_row_q),
      .rcol_i  (rd_col_q),
      .rdata_o (rdata[b])
    );
  end

  always_comb begin
    out_valid = (st_q[rd_bank_q] == BankReading);
    out_data  = out_valid ? rdata[rd_bank_q] : '0;
    out_row   = rd_row_q;
    out_col   = rd_col_q;
    out_last  = out_valid && at_last;
    tile_done = tile_done_q;
    overflow  = ovf_q;
    proto_err = perr_q;
  end

endmodule
